// File: rtl/sprite_pixel_pipeline_if.sv
// Bus for sprite_pixel_pipeline: object shadow inputs, pixel request and pixel result handshakes.
// The master side drives requests and object data; the slave side is the pipeline.
interface sprite_pixel_pipeline_if #(
  parameter int unsigned NUM_OBJ  = 3,
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned COLOUR_W = 24
);
  logic                          frame_start;
  logic [NUM_OBJ*2*COORD_W-1:0]  obj_pos;
  logic [NUM_OBJ*2*COORD_W-1:0]  obj_size;
  logic [NUM_OBJ*COLOUR_W-1:0]   obj_colour;
  logic [COLOUR_W-1:0]           bg_colour;
  logic                          in_valid;
  logic                          in_ready;
  logic [COORD_W-1:0]            pix_x;
  logic [COORD_W-1:0]            pix_y;
  logic                          out_valid;
  logic                          out_ready;
  logic [COLOUR_W-1:0]           pixel_out;
  logic                          collision;

  modport master (
    output frame_start, obj_pos, obj_size, obj_colour, bg_colour,
    output in_valid, pix_x, pix_y, out_ready,
    input  in_ready, out_valid, pixel_out, collision
  );

  modport slave (
    input  frame_start, obj_pos, obj_size, obj_colour, bg_colour,
    input  in_valid, pix_x, pix_y, out_ready,
    output in_ready, out_valid, pixel_out, collision
  );
endinterface

// File: rtl/sprite_pixel_pipeline.sv
// Two-stage sprite resolver: S1 registers the rectangle hit vector, S2 the priority-muxed colour.
// Define SPRITE_PIXEL_COLLISION_EN to build the sticky multi-object overlap flag.
module sprite_pixel_pipeline #(
  parameter int unsigned NUM_OBJ  = 3,
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned COLOUR_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sprite_pixel_pipeline_if.slave bus
);
  localparam int unsigned PairW = 2 * COORD_W;

  // Active object set, only ever updated by frame_start
  logic [NUM_OBJ*PairW-1:0]    r_pos;
  logic [NUM_OBJ*PairW-1:0]    r_size;
  logic [NUM_OBJ*COLOUR_W-1:0] r_colour;
  logic [COLOUR_W-1:0]         r_bg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos    <= '0;
      r_size   <= '0;
      r_colour <= '0;
      r_bg     <= '0;
    end else if (bus.frame_start) begin
      r_pos    <= bus.obj_pos;
      r_size   <= bus.obj_size;
      r_colour <= bus.obj_colour;
      r_bg     <= bus.bg_colour;
    end
  end

  logic                        r_s1_valid;
  logic [NUM_OBJ-1:0]          r_s1_hit;
  logic [NUM_OBJ*COLOUR_W-1:0] r_s1_colour;
  logic [COLOUR_W-1:0]         r_s1_bg;
  logic                        r_s2_valid;
  logic [COLOUR_W-1:0]         r_s2_colour;

  logic                        w_s1_en;
  logic                        w_s2_en;
  logic [NUM_OBJ-1:0]          w_hit;
  logic [COORD_W:0]            w_px;
  logic [COORD_W:0]            w_py;
  logic [COLOUR_W-1:0]         w_chain [NUM_OBJ+1];

  assign w_px = {1'b0, bus.pix_x};
  assign w_py = {1'b0, bus.pix_y};

  // Extra top bit keeps x+W from wrapping; a zero extent can never satisfy lo <= p < lo.
  for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
    logic [COORD_W:0] w_x0, w_y0, w_x1, w_y1;
    assign w_x0 = {1'b0, r_pos[gi*PairW+COORD_W +: COORD_W]};
    assign w_y0 = {1'b0, r_pos[gi*PairW +: COORD_W]};
    assign w_x1 = w_x0 + {1'b0, r_size[gi*PairW+COORD_W +: COORD_W]};
    assign w_y1 = w_y0 + {1'b0, r_size[gi*PairW +: COORD_W]};
    assign w_hit[gi] = (w_px >= w_x0) && (w_px < w_x1) && (w_py >= w_y0) && (w_py < w_y1);
    assign w_chain[gi] = r_s1_hit[gi] ? r_s1_colour[gi*COLOUR_W +: COLOUR_W] : w_chain[gi+1];
  end
  assign w_chain[NUM_OBJ] = r_s1_bg;

  assign w_s2_en = bus.out_ready || !r_s2_valid;
  assign w_s1_en = w_s2_en || !r_s1_valid;

  // The colour table rides along with the hit vector so a later frame_start cannot recolour it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_hit    <= '0;
      r_s1_colour <= '0;
      r_s1_bg     <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_hit    <= w_hit;
        r_s1_colour <= r_colour;
        r_s1_bg     <= r_bg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_colour <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_colour <= w_chain[0];
    end
  end

  assign bus.in_ready  = w_s1_en;
  assign bus.out_valid = r_s2_valid;
  assign bus.pixel_out = r_s2_colour;

`ifdef SPRITE_PIXEL_COLLISION_EN
  logic [3:0] w_cnt [NUM_OBJ+1];
  logic       w_multi;
  logic       r_s1_multi;
  logic       r_s2_multi;
  logic       r_collision;

  assign w_cnt[0] = 4'd0;
  for (genvar gc = 0; gc < NUM_OBJ; gc++) begin : g_cnt
    assign w_cnt[gc+1] = w_cnt[gc] + {3'b000, w_hit[gc]};
  end
  assign w_multi = (w_cnt[NUM_OBJ] >= 4'd2);

  // A set from an emitted overlap beats a coincident frame_start clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_multi  <= 1'b0;
      r_s2_multi  <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      if (w_s1_en && bus.in_valid) r_s1_multi <= w_multi;
      if (w_s2_en && r_s1_valid)   r_s2_multi <= r_s1_multi;
      if (r_s2_valid && bus.out_ready && r_s2_multi) r_collision <= 1'b1;
      else if (bus.frame_start)                      r_collision <= 1'b0;
    end
  end

  assign bus.collision = r_collision;
`else
  assign bus.collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_pixel_pipeline.sv
// Self-checking bench for sprite_pixel_pipeline: directed table, corner sequences and a
// randomized run scored against a rectangle-coverage reference model.
module tb_sprite_pixel_pipeline;
  localparam int NumObj  = 3;
  localparam int CoordW  = 16;
  localparam int ColourW = 24;
`ifdef SPRITE_PIXEL_COLLISION_EN
  localparam bit CollEn = 1'b1;
`else
  localparam bit CollEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_pixel_pipeline_if #(.NUM_OBJ(NumObj), .COORD_W(CoordW), .COLOUR_W(ColourW)) bus ();

  sprite_pixel_pipeline #(.NUM_OBJ(NumObj), .COORD_W(CoordW), .COLOUR_W(ColourW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [ColourW-1:0] colour; bit multi; } exp_t;
  typedef struct { int cfg; logic [15:0] px; logic [15:0] py; logic [23:0] exp_c; string name; } vec_t;

  exp_t exp_q[$];
  vec_t vt[$];
  int m_x[NumObj], m_y[NumObj], m_w[NumObj], m_h[NumObj];
  logic [ColourW-1:0] m_col[NumObj];
  logic [ColourW-1:0] m_bg;
  bit m_coll;
  int n_vec = 0, n_err = 0, n_emit = 0;
  bit hold_pending = 1'b0;
  logic [ColourW-1:0] hold_val;
  bit last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // First covering object in index order wins; count coverers for the overlap flag
  function automatic exp_t ref_pixel(input int px, input int py);
    exp_t e;
    int hits = 0;
    e.colour = m_bg;
    for (int i = 0; i < NumObj; i++) begin
      if (px >= m_x[i] && px < m_x[i] + m_w[i] && py >= m_y[i] && py < m_y[i] + m_h[i]) begin
        if (hits == 0) e.colour = m_col[i];
        hits++;
      end
    end
    e.multi = (hits >= 2);
    return e;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NumObj; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_h[i] = 0; m_col[i] = '0;
    end
    m_bg = '0;
    m_coll = 1'b0;
    exp_q.delete();
    hold_pending = 1'b0;
  endtask

  task automatic capture_cfg();
    for (int i = 0; i < NumObj; i++) begin
      m_x[i]   = int'(bus.obj_pos[i*2*CoordW+CoordW +: CoordW]);
      m_y[i]   = int'(bus.obj_pos[i*2*CoordW +: CoordW]);
      m_w[i]   = int'(bus.obj_size[i*2*CoordW+CoordW +: CoordW]);
      m_h[i]   = int'(bus.obj_size[i*2*CoordW +: CoordW]);
      m_col[i] = bus.obj_colour[i*ColourW +: ColourW];
    end
    m_bg = bus.bg_colour;
  endtask

  // One clock: observe at the negedge, commit the model at the posedge, return 1ns later
  task automatic tick();
    exp_t e;
    bit emit_multi = 1'b0;
    bit fs;
    @(negedge clk);
    if (hold_pending) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_pixel", 32'(bus.pixel_out), 32'(hold_val));
    end
    if (!bus.out_valid || bus.out_ready) check("in_ready", 32'(bus.in_ready), 32'd1);
    check("collision", 32'(bus.collision), 32'(m_coll));
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL spurious_out: got pixel %h, expected no output", bus.pixel_out);
      end else begin
        e = exp_q.pop_front();
        check("pixel", 32'(bus.pixel_out), 32'(e.colour));
        n_emit++;
        emit_multi = e.multi;
      end
    end
    hold_pending = bus.out_valid && !bus.out_ready;
    hold_val     = bus.pixel_out;
    last_acc     = bus.in_valid && bus.in_ready;
    if (last_acc) exp_q.push_back(ref_pixel(int'(bus.pix_x), int'(bus.pix_y)));
    fs = bus.frame_start;
    @(posedge clk);
    if (emit_multi && CollEn) m_coll = 1'b1;
    else if (fs)              m_coll = 1'b0;
    if (fs) capture_cfg();
    #1;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.frame_start = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_obj(input int i, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] w, input logic [15:0] h, input logic [23:0] col);
    bus.obj_pos[i*2*CoordW +: 2*CoordW]  = {x, y};
    bus.obj_size[i*2*CoordW +: 2*CoordW] = {w, h};
    bus.obj_colour[i*ColourW +: ColourW] = col;
  endtask

  task automatic commit();
    drain();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic load_cfg(input int cfg);
    bus.obj_pos = '0; bus.obj_size = '0; bus.obj_colour = '0;
    case (cfg)
      0: begin set_obj(0, 16'd10, 16'd20, 16'd15, 16'd100, 24'hFFFFFF); bus.bg_colour = 24'h123456; end
      1: begin set_obj(0, 16'hFFF0, 16'd0, 16'h0020, 16'd10, 24'hABCDEF); bus.bg_colour = 24'h0F0F0F; end
      default: begin
        set_obj(0, 16'd40, 16'd40, 16'd20, 16'd20, 24'h0000FF);
        set_obj(1, 16'd45, 16'd45, 16'd10, 16'd10, 24'h00FF00);
        bus.bg_colour = 24'h202020;
      end
    endcase
    commit();
  endtask

  task automatic send_check(input string name, input logic [15:0] px, input logic [15:0] py,
                            input logic [23:0] req, input bit fs);
    drain();
    bus.pix_x = px; bus.pix_y = py; bus.in_valid = 1'b1; bus.frame_start = fs;
    tick();
    bus.in_valid = 1'b0; bus.frame_start = 1'b0;
    check({name, "_early"}, 32'(bus.out_valid), 32'd0);
    tick();
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_pixel"}, 32'(bus.pixel_out), 32'(req));
  endtask

  task automatic add_vec(input int cfg, input logic [15:0] px, input logic [15:0] py,
                         input logic [23:0] req, input string name);
    vec_t v;
    v.cfg = cfg; v.px = px; v.py = py; v.exp_c = req; v.name = name;
    vt.push_back(v);
  endtask

  task automatic randomize_cfg();
    for (int i = 0; i < NumObj; i++) begin
      set_obj(i,
              ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 100)) : 16'(32'hFFC0 + $urandom_range(0, 63)),
              16'($urandom_range(0, 100)), 16'($urandom_range(0, 60)), 16'($urandom_range(0, 60)),
              24'($urandom));
    end
    bus.bg_colour = 24'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cur, start, sent, acc;
    bus.frame_start = 1'b0; bus.obj_pos = '0; bus.obj_size = '0; bus.obj_colour = '0;
    bus.bg_colour = '0; bus.in_valid = 1'b0; bus.pix_x = '0; bus.pix_y = '0; bus.out_ready = 1'b1;
    reset_model();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_pixel", 32'(bus.pixel_out), 32'd0);
    check("rst_collision", 32'(bus.collision), 32'd0);
    rst_n = 1'b1;
    #1 check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    send_check("rst_cfg_bg0", 16'd10, 16'd20, 24'h000000, 1'b0);

    add_vec(0, 16'd10, 16'd20, 24'hFFFFFF, "c0_topleft");
    add_vec(0, 16'd24, 16'd119, 24'hFFFFFF, "c0_botright");
    add_vec(0, 16'd25, 16'd20, 24'h123456, "c0_xend");
    add_vec(0, 16'd9, 16'd20, 24'h123456, "c0_xbefore");
    add_vec(0, 16'd10, 16'd19, 24'h123456, "c0_ybefore");
    add_vec(0, 16'd24, 16'd120, 24'h123456, "c0_yend");
    add_vec(1, 16'hFFFF, 16'd0, 24'hABCDEF, "c1_nowrap_hit");
    add_vec(1, 16'h0005, 16'd0, 24'h0F0F0F, "c1_wrap_miss");
    add_vec(1, 16'hFFF0, 16'd9, 24'hABCDEF, "c1_corner");
    add_vec(1, 16'hFFEF, 16'd5, 24'h0F0F0F, "c1_left");
    add_vec(1, 16'hFFFF, 16'd10, 24'h0F0F0F, "c1_yend");
    add_vec(2, 16'd50, 16'd50, 24'h0000FF, "c2_overlap");
    add_vec(2, 16'd46, 16'd46, 24'h0000FF, "c2_overlap2");
    add_vec(2, 16'd59, 16'd59, 24'h0000FF, "c2_obj0_only");
    add_vec(2, 16'd70, 16'd70, 24'h202020, "c2_bg");
    cur = -1;
    foreach (vt[k]) begin
      if (vt[k].cfg != cur) begin load_cfg(vt[k].cfg); cur = vt[k].cfg; end
      send_check(vt[k].name, vt[k].px, vt[k].py, vt[k].exp_c, 1'b0);
    end
    drain();
    check("coll_after_emit", 32'(bus.collision), 32'(CollEn));
    commit();
    check("coll_after_fs", 32'(bus.collision), 32'd0);

    // Streaming with out_ready 1,0,0,1
    load_cfg(0);
    start = n_emit; sent = 0;
    for (int c = 0; c < 64 && (n_emit - start) < 8; c++) begin
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      bus.in_valid  = (sent < 8);
      bus.pix_x = 16'(8 + 2 * sent); bus.pix_y = 16'd20;
      tick();
      if (last_acc) sent++;
    end
    check("stream_count", 32'(n_emit - start), 32'd8);
    drain();

    acc = 0;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      bus.pix_x = 16'($urandom_range(0, 40)); bus.pix_y = 16'($urandom_range(0, 140));
      tick();
      acc += int'(last_acc);
    end
    check("throughput", 32'(acc), 32'd16);
    drain();

    // Shadow inputs change without frame_start
    set_obj(0, 16'd10, 16'd20, 16'd15, 16'd100, 24'h00AA00);
    bus.bg_colour = 24'h555555;
    send_check("stale_col", 16'd12, 16'd30, 24'hFFFFFF, 1'b0);
    send_check("stale_bg", 16'd100, 16'd5, 24'h123456, 1'b0);
    send_check("fs_coincident", 16'd12, 16'd30, 24'hFFFFFF, 1'b1);
    send_check("new_col", 16'd12, 16'd30, 24'h00AA00, 1'b0);
    send_check("new_bg", 16'd100, 16'd5, 24'h555555, 1'b0);

    // Reset with two pixels in flight
    load_cfg(0);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.pix_x = 16'd10; bus.pix_y = 16'd20;
    tick();
    bus.pix_x = 16'd11;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("inflight_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_async_valid", 32'(bus.out_valid), 32'd0);
    check("rst_async_pixel", 32'(bus.pixel_out), 32'd0);
    reset_model();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; bus.out_ready = 1'b1;
    #1 check("rel2_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    start = n_emit;
    repeat (4) tick();
    check("rst_no_stale", 32'(n_emit - start), 32'd0);
    send_check("rst_cfg_cleared", 16'd10, 16'd20, 24'h000000, 1'b0);

    // Randomized traffic against the reference model
    randomize_cfg();
    commit();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 4) randomize_cfg();
      bus.frame_start = ($urandom_range(0, 29) == 0);
      if (!bus.in_valid || last_acc) begin
        bus.pix_x = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 160))
                                                : 16'(32'hFFA0 + $urandom_range(0, 95));
        bus.pix_y = 16'($urandom_range(0, 160));
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sprite_pixel_pipeline.md
SPRITE_PIXEL_PIPELINE -- requirements
Module: sprite_pixel_pipeline

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 3, meaning the number of rectangular objects (1..8).
REQ-002 SHALL have parameter COORD_W, default 16, meaning the unsigned coordinate width.
REQ-003 SHALL have parameter COLOUR_W, default 24, meaning the pixel colour width.
REQ-004 SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  in  1  the reset: asynchronous, active-low.
REQ-006 SHALL have port frame_start  in  1  a one-cycle pulse that commits shadow object registers.
REQ-007 SHALL have port obj_pos  in  NUM_OBJ*2*COORD_W  the object {x,y} pairs, object 0 in the LSBs.
REQ-008 SHALL have port obj_size  in  NUM_OBJ*2*COORD_W  the object {width,height} pairs.
REQ-009 SHALL have port obj_colour  in  NUM_OBJ*COLOUR_W  the per-object colour.
REQ-010 SHALL have port bg_colour  in  COLOUR_W  the background colour.
REQ-011 SHALL have port in_valid / in_ready  in / out  1 / 1  the pixel request handshake.
REQ-012 SHALL have port pix_x, pix_y  in  COORD_W each  the requested pixel coordinate.
REQ-013 SHALL have port out_valid / out_ready  out / in  1 / 1  the pixel result handshake.
REQ-014 SHALL have port pixel_out  out  COLOUR_W  the resolved colour.
REQ-015 SHALL have port collision  out  1  the sticky object-overlap flag (see Configuration).

Function
REQ-016 SHALL latch obj_pos, obj_size, obj_colour and bg_colour into active registers only on the clk edge where frame_start=1, so mid-frame changes on the inputs have no effect.
REQ-017 SHALL compute a hit for object i iff objX<=pix_x<objX+W and objY<=pix_y<objY+H, evaluated unsigned at COORD_W+1 bits so that objX+W never wraps.
REQ-018 SHALL treat W=0 or H=0 as never hit.
REQ-019 SHALL give priority to the lowest-index hit object; with no hit, pixel_out SHALL be the active bg_colour.
REQ-020 SHALL be a 2-stage pipeline (S1: compare, hit vector registered; S2: priority mux, colour registered), so latency from an accepted request to out_valid is 2 cycles with no stalls.
REQ-021 SHALL accept a transfer when in_valid&&in_ready, and emit one when out_valid&&out_ready.
REQ-022 SHALL drive in_ready = out_ready || !S2_valid || !S1_valid (combinational skid-free stall); a stalled stage SHALL hold its data and valid unchanged.
REQ-023 SHALL sustain 1 pixel/cycle throughput when out_ready is held at 1.
REQ-024 SHALL keep outputs stable while out_valid=1 and out_ready=0.
REQ-025 SHALL apply a frame_start coincident with an in-flight request only to requests accepted on later cycles; S1/S2 SHALL use the copy captured at acceptance (the hit vector and colour index travel with the data).
REQ-026 SHALL hold pixel order equal to request order with no drops or duplicates.

Reset
REQ-027 SHALL, while rst_n=0, clear S1_valid, S2_valid, out_valid, pixel_out, collision, and all active object registers (size 0 gives no hits, bg 0).
REQ-028 SHALL discard in-flight pixels on reset mid-operation; in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-029 SHALL, with macro SPRITE_PIXEL_COLLISION_EN defined, set collision when any emitted pixel had 2 or more hit objects; the flag SHALL stay set until the next frame_start, which clears it (if a set and a clear coincide, set wins).
REQ-030 SHALL, without SPRITE_PIXEL_COLLISION_EN, tie collision to 0 and synthesise no popcount logic.

Verification
REQ-031 SHALL cover: obj0={10,20,15,100,FFFFFF}, frame_start, request (10,20), (24,119), (25,20) -> FFFFFF, FFFFFF, bg, each 2 cycles later.
REQ-032 SHALL cover: obj0 and obj1 both cover (50,50), colours 0000FF and 00FF00 -> 0000FF; with collision EN, collision=1 after emit and 0 after the next frame_start.
REQ-033 SHALL cover: obj x=FFF0, W=0020, pix_x=FFFF -> hit; pix_x=0005 -> no hit (no wrap).
REQ-034 SHALL cover: streaming 8 requests with out_ready toggling 1,0,0,1 -> 8 results in order, outputs held during stalls.
REQ-035 SHALL cover: inputs changed without frame_start mid-stream -> old colours persist until frame_start.
REQ-036 SHALL cover: rst_n low with 2 pixels in flight -> out_valid=0 at once, no stale outputs after release.
